kernel_mem_responder: RTL and testbench
=======================================

KERNEL_MEM_RESPONDER -- requirements
Module: kernel_mem_responder

Interface
REQ-001 SHALL have parameter LINES, default 1024: number of 512-bit lines in backing RAM (power of two).
REQ-002 SHALL have parameter CMD_DEPTH, default 4: read-command FIFO entries.
REQ-003 SHALL have parameter MAX_BURST, default 8: largest legal burstcount.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (sole clock), rst input 1 (async, active-high).
REQ-005 SHALL have port mem_address, input, 33: byte address; bits [5:0] ignored.
REQ-006 SHALL have ports mem_read and mem_write, input, 1 each: read and write command strobes.
REQ-007 SHALL have ports mem_writedata input 512, mem_byteenable input 64, and mem_burstcount input 4.
REQ-008 SHALL have port mem_waitrequest, output, 1: command/beat stall.
REQ-009 SHALL have ports mem_readdata output 512 and mem_readdatavalid output 1.
REQ-010 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-011 SHALL act as the Avalon-MM burst slave serving a kernel mem_0 master port; line index = mem_address[32:6] modulo LINES.
REQ-012 SHALL drive mem_waitrequest = 1 exactly when the read-command FIFO holds CMD_DEPTH entries, independent of mem_read/mem_write.
REQ-013 SHALL accept a command or write beat in a cycle where (mem_read|mem_write) & !mem_waitrequest.
REQ-014 SHALL treat burstcount 0 as 1; SHALL clamp burstcount > MAX_BURST to MAX_BURST and set err.
REQ-015 SHALL, on write-burst start, latch line index and count, write beat k to line base+k, and accept the remaining beats with no address sampling.
REQ-016 SHALL apply mem_byteenable per byte lane on each write beat; lanes with enable 0 SHALL retain their old contents.
REQ-017 SHALL commit each write beat to RAM in its acceptance cycle, so a read accepted in any later cycle returns the new data.
REQ-018 SHALL push each accepted read (line index, count) into the FIFO, in order.
REQ-019 SHALL use a read engine with states IDLE and BURST: IDLE->BURST on non-empty FIFO (pop); BURST->IDLE after the last beat unless the FIFO is non-empty, in which case it SHALL pop and continue with no gap.
REQ-020 SHALL, for a read accepted at cycle T with the engine idle and FIFO empty, assert first mem_readdatavalid at T+2; subsequent beats SHALL follow on consecutive cycles.
REQ-021 SHALL assert mem_readdatavalid exactly once per beat; mem_readdata SHALL be valid only while it is asserted.
REQ-022 SHALL wrap burst addresses from line LINES-1 to line 0.
REQ-023 SHALL, when mem_read & mem_write are asserted together, treat the cycle as a write and set err.
REQ-024 SHALL, when mem_read is asserted during an unfinished write burst, ignore the read and set err.
REQ-025 SHALL hold err at 1 until reset.

Reset
REQ-026 SHALL, on rst asserted, immediately drive mem_readdatavalid=0, mem_waitrequest=0, and err=0, clear the FIFO, place the engine in IDLE, and abandon any in-flight write burst.
REQ-027 SHALL NOT clear RAM contents on reset; after reset deassertion the block SHALL accept commands in the next cycle.

Structure
REQ-028 SHALL place LINE_BYTES=64, DATA_W=512, ADDR_W=33, BURST_W=4, and the read-engine state enum in shared package kernel_mem_pkg.
REQ-029 SHALL instantiate one sub-module, kernel_mem_cmd_fifo (synchronous FIFO, CMD_DEPTH x {line, count}); the RAM SHALL be an inferred simple dual-port array.

Verification
REQ-030 SHALL verify single write then read: write line 5 = 0xA5.., byteenable all-ones; read line 5 burst 1 -> one beat 0xA5.. at T+2.
REQ-031 SHALL verify burst with byte enables: write burst 4 at address 0x100 with byteenable 0x0F on beat 2; read burst 4 -> beat 2 changes only bytes 0-3, other beats fully written.
REQ-032 SHALL verify back-to-back reads: 5 reads of burst 8 issued every cycle with CMD_DEPTH=4 -> waitrequest high once 4 are queued; 40 consecutive valid beats, in order.
REQ-033 SHALL verify wrap: read burst 4 at line LINES-2 -> lines LINES-2, LINES-1, 0, 1.
REQ-034 SHALL verify errors: read & write together, or burstcount 12 -> err=1 and held; the clamped burst returns 8 beats.
REQ-035 SHALL verify reset mid-read: rst asserted at beat 3 of 8 -> readdatavalid 0 immediately, no further beats, and RAM data preserved on a re-read.

Source files
------------

// File: rtl/kernel_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kernel_mem_pkg : shared constants, read-engine states and burst helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package kernel_mem_pkg;

   localparam int LINE_BYTES = 64;
   localparam int DATA_W     = 512;
   localparam int ADDR_W     = 33;
   localparam int BURST_W    = 4;

   typedef enum logic [0:0] {
      RD_IDLE  = 1'b0,
      RD_BURST = 1'b1
   } rd_state_t;

   // Burstcount 0 means one beat; oversize requests saturate at max_bc.
   function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc,
                                                   input logic [BURST_W-1:0] max_bc);
      if (bc == '0)
         return BURST_W'(1);
      else if (bc > max_bc)
         return max_bc;
      else
         return bc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_mem_cmd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kernel_mem_cmd_fifo : synchronous FIFO holding queued read commands
// Rev 1.0
// ---------------------------------------------------------------------------
module kernel_mem_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == CNT_W'(DEPTH));
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/kernel_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kernel_mem_responder : Avalon-MM burst slave backed by a 512-bit line RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module kernel_mem_responder
   import kernel_mem_pkg::*;
#(
   parameter int LINES     = 1024,
   parameter int CMD_DEPTH = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     mem_address,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DATA_W-1:0]     mem_writedata,
   input  logic [LINE_BYTES-1:0] mem_byteenable,
   input  logic [BURST_W-1:0]    mem_burstcount,
   output logic                  mem_waitrequest,
   output logic [DATA_W-1:0]     mem_readdata,
   output logic                  mem_readdatavalid,
   output logic                  err
);

   localparam int                 LINE_W   = $clog2(LINES);
   localparam int                 OFF_W    = $clog2(LINE_BYTES);
   localparam int                 CMD_W    = LINE_W + BURST_W;
   localparam logic [BURST_W-1:0] MAX_BC   = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] BC_ONE   = BURST_W'(1);
   localparam logic [LINE_W-1:0]  LINE_ONE = LINE_W'(1);

   logic [DATA_W-1:0]  r_ram [LINES];
   logic               r_wr_active;
   logic [LINE_W-1:0]  r_wr_line;
   logic [BURST_W-1:0] r_wr_left;
   rd_state_t          r_state;
   logic [LINE_W-1:0]  r_rd_line;
   logic [BURST_W-1:0] r_rd_left;

   logic [LINE_W-1:0]  w_cmd_line;
   logic [LINE_W-1:0]  w_wr_line;
   logic [BURST_W-1:0] w_bc_eff;
   logic               w_bc_bad;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic               w_err_set;
   logic [CMD_W-1:0]   w_head;
   logic [LINE_W-1:0]  w_head_line;
   logic [BURST_W-1:0] w_head_cnt;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_unused_addr;

   // Line index wraps modulo LINES by keeping only the low index bits.
   assign w_cmd_line    = mem_address[OFF_W +: LINE_W];
   assign w_unused_addr = ^{mem_address[OFF_W-1:0], mem_address[ADDR_W-1:OFF_W+LINE_W]};
   assign w_bc_eff      = eff_burst(mem_burstcount, MAX_BC);
   assign w_bc_bad      = (mem_burstcount > MAX_BC);

   assign mem_waitrequest = w_full;
   assign w_wr_acc  = mem_write & ~mem_waitrequest;
   assign w_rd_acc  = mem_read & ~mem_write & ~mem_waitrequest & ~r_wr_active;
   assign w_wr_line = r_wr_active ? r_wr_line : w_cmd_line;
   assign w_err_set = (mem_read & mem_write & ~mem_waitrequest)
                    | (mem_read & ~mem_write & ~mem_waitrequest & r_wr_active)
                    | (w_bc_bad & (w_rd_acc | (w_wr_acc & ~r_wr_active)));

   assign {w_head_line, w_head_cnt} = w_head;
   assign w_pop = ~w_empty & ((r_state == RD_IDLE) | (r_rd_left == BC_ONE));

   kernel_mem_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_rd_acc),
      .din   ({w_cmd_line, w_bc_eff}),
      .pop   (w_pop),
      .dout  (w_head),
      .empty (w_empty),
      .full  (w_full)
   );

   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (mem_byteenable[b])
               r_ram[w_wr_line][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end
      end
   end

   // Write-burst tracker: only the first beat samples address and count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_active <= 1'b0;
         r_wr_line   <= '0;
         r_wr_left   <= '0;
         err         <= 1'b0;
      end else begin
         if (w_err_set)
            err <= 1'b1;
         if (w_wr_acc) begin
            if (!r_wr_active) begin
               r_wr_active <= (w_bc_eff > BC_ONE);
               r_wr_line   <= w_cmd_line + LINE_ONE;
               r_wr_left   <= w_bc_eff - BC_ONE;
            end else begin
               r_wr_active <= (r_wr_left > BC_ONE);
               r_wr_line   <= r_wr_line + LINE_ONE;
               r_wr_left   <= r_wr_left - BC_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state           <= RD_IDLE;
         r_rd_line         <= '0;
         r_rd_left         <= '0;
         mem_readdata      <= '0;
         mem_readdatavalid <= 1'b0;
      end else begin
         mem_readdatavalid <= 1'b0;
         case (r_state)
            RD_IDLE: begin
               if (!w_empty) begin
                  mem_readdata      <= r_ram[w_head_line];
                  mem_readdatavalid <= 1'b1;
                  r_rd_line         <= w_head_line + LINE_ONE;
                  r_rd_left         <= w_head_cnt - BC_ONE;
                  r_state           <= (w_head_cnt > BC_ONE) ? RD_BURST : RD_IDLE;
               end
            end
            RD_BURST: begin
               mem_readdata      <= r_ram[r_rd_line];
               mem_readdatavalid <= 1'b1;
               if (r_rd_left == BC_ONE) begin
                  // Chain straight into the next queued command without a gap.
                  if (!w_empty) begin
                     r_rd_line <= w_head_line;
                     r_rd_left <= w_head_cnt;
                  end else begin
                     r_state <= RD_IDLE;
                  end
               end else begin
                  r_rd_line <= r_rd_line + LINE_ONE;
                  r_rd_left <= r_rd_left - BC_ONE;
               end
            end
            default: r_state <= RD_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_kernel_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_kernel_mem_responder : directed self-checking bench for kernel_mem_responder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_kernel_mem_responder;

   localparam int LINES = 1024;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [32:0]  mem_address = '0;
   logic         mem_read = 1'b0;
   logic         mem_write = 1'b0;
   logic [511:0] mem_writedata = '0;
   logic [63:0]  mem_byteenable = '0;
   logic [3:0]   mem_burstcount = '0;
   logic         mem_waitrequest;
   logic [511:0] mem_readdata;
   logic         mem_readdatavalid;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [511:0] q_data[$];
   int           q_cyc[$];

   kernel_mem_responder #(
      .LINES     (LINES),
      .CMD_DEPTH (4),
      .MAX_BURST (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_byteenable    (mem_byteenable),
      .mem_burstcount    (mem_burstcount),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .err               (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_readdatavalid === 1'b1) begin
         q_data.push_back(mem_readdata);
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] pat(input int line, input logic [7:0] tag);
      logic [511:0] p;
      int l;
      l = line % LINES;
      for (int i = 0; i < 16; i++)
         p[i*32 +: 32] = {tag, 8'(i), 16'(l)};
      return p;
   endfunction

   task automatic wait_free();
      int g;
      g = 0;
      while (mem_waitrequest === 1'b1 && g < 64) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 64)
         chk("stall_timeout", 512'(g), 512'(0));
   endtask

   task automatic beat(input logic rd, input logic wr, input int line, input logic [3:0] bc,
                       input logic [511:0] wd, input logic [63:0] be, output int t);
      mem_read       = rd;
      mem_write      = wr;
      mem_address    = 33'(line) * 33'd64;
      mem_burstcount = bc;
      mem_writedata  = wd;
      mem_byteenable = be;
      wait_free();
      t = cyc;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic clrq();
      q_data.delete();
      q_cyc.delete();
   endtask

   // Later beats deliberately carry address 0 / burstcount 0 to show they are not sampled.
   task automatic wr_burst(input int line, input int n, input logic [3:0] bc, input logic [7:0] tag,
                           input int sbeat, input logic [63:0] sbe);
      int t;
      for (int k = 0; k < n; k++)
         beat(1'b0, 1'b1, (k == 0) ? line : 0, (k == 0) ? bc : 4'd0, pat(line + k, tag),
              (k == sbeat) ? sbe : {64{1'b1}}, t);
      idle();
   endtask

   task automatic rd(input int line, input logic [3:0] bc, output int t);
      beat(1'b1, 1'b0, line, bc, '0, '0, t);
   endtask

   task automatic get_beats(input int n, input string tag);
      int g;
      g = 0;
      while (q_data.size() < n && g < 400) begin
         @(negedge clk); #1;
         g++;
      end
      repeat (4) @(negedge clk);
      #1;
      chk({tag, "_count"}, 512'(q_data.size()), 512'(n));
   endtask

   initial begin
      int t, t0, g;
      logic [511:0] e, e_old;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 512'(mem_readdatavalid), 512'(0));
      chk("rst_wait", 512'(mem_waitrequest), 512'(0));
      chk("rst_err", 512'(err), 512'(0));
      rst = 1'b0;

      // single write then read, plus burstcount 0 treated as one beat
      beat(1'b0, 1'b1, 5, 4'd1, {64{8'hA5}}, {64{1'b1}}, t);
      idle();
      clrq();
      rd(5, 4'd1, t);
      idle();
      get_beats(1, "single");
      chk("single_data", q_data[0], {64{8'hA5}});
      chk("single_lat", 512'(q_cyc[0]), 512'(t + 2));
      clrq();
      rd(5, 4'd0, t);
      idle();
      get_beats(1, "bc0");
      chk("bc0_data", q_data[0], {64{8'hA5}});

      // burst with a partial byte enable on beat 2 (address 0x100 = line 4)
      wr_burst(4, 4, 4'd4, 8'h11, -1, '1);
      wr_burst(4, 4, 4'd4, 8'h22, 2, 64'h0F);
      clrq();
      rd(4, 4'd4, t);
      idle();
      get_beats(4, "be");
      for (int k = 0; k < 4; k++) begin
         e = pat(4 + k, 8'h22);
         if (k == 2) begin
            e_old = pat(6, 8'h11);
            e = {e_old[511:32], e[31:0]};
         end
         chk($sformatf("be_beat%0d", k), q_data[k], e);
      end
      chk("be_last_cycle", 512'(q_cyc[3]), 512'(t + 5));

      // back-to-back reads: five bursts of 8, one per cycle
      for (int i = 0; i < 5; i++)
         wr_burst(16 + 8 * i, 8, 4'd8, 8'h30, -1, '1);
      clrq();
      t0 = 0;
      for (int i = 0; i < 5; i++) begin
         rd(16 + 8 * i, 4'd8, t);
         if (i == 0) t0 = t;
      end
      chk("b2b_wait_full", 512'(mem_waitrequest), 512'(1));
      idle();
      get_beats(40, "b2b");
      for (int j = 0; j < 40; j++)
         chk($sformatf("b2b_beat%0d", j), q_data[j], pat(16 + j, 8'h30));
      chk("b2b_first", 512'(q_cyc[0]), 512'(t0 + 2));
      chk("b2b_gapless", 512'(q_cyc[39] - q_cyc[0]), 512'(39));

      // address wrap from LINES-1 to 0
      wr_burst(LINES - 2, 4, 4'd4, 8'h44, -1, '1);
      clrq();
      rd(LINES - 2, 4'd4, t);
      idle();
      get_beats(4, "wrap");
      for (int k = 0; k < 4; k++)
         chk($sformatf("wrap_beat%0d", k), q_data[k], pat(LINES - 2 + k, 8'h44));

      // error cases: read+write together is a write; burstcount 12 clamps to 8
      chk("err_clean", 512'(err), 512'(0));
      beat(1'b1, 1'b1, 100, 4'd1, pat(100, 8'h55), {64{1'b1}}, t);
      idle();
      chk("err_rw", 512'(err), 512'(1));
      clrq();
      rd(100, 4'd1, t);
      idle();
      get_beats(1, "rw");
      chk("rw_data", q_data[0], pat(100, 8'h55));
      clrq();
      rd(16, 4'd12, t);
      idle();
      get_beats(8, "clamp");
      chk("clamp_first", q_data[0], pat(16, 8'h30));
      chk("clamp_last", q_data[7], pat(23, 8'h30));
      chk("err_held", 512'(err), 512'(1));

      // reset in the middle of a read burst
      clrq();
      rd(16, 4'd8, t);
      idle();
      g = 0;
      while (q_data.size() < 3 && g < 100) begin
         @(negedge clk); #1;
         g++;
      end
      rst = 1'b1;
      #1;
      chk("midrst_valid", 512'(mem_readdatavalid), 512'(0));
      chk("midrst_wait", 512'(mem_waitrequest), 512'(0));
      chk("midrst_err", 512'(err), 512'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      chk("midrst_nomore", 512'(q_data.size()), 512'(3));
      clrq();
      rd(16, 4'd8, t);
      idle();
      get_beats(8, "reread");
      for (int k = 0; k < 8; k++)
         chk($sformatf("reread_beat%0d", k), q_data[k], pat(16 + k, 8'h30));

      // read during an unfinished write burst is ignored and flags err
      clrq();
      beat(1'b0, 1'b1, 200, 4'd2, pat(200, 8'h66), {64{1'b1}}, t);
      beat(1'b1, 1'b0, 16, 4'd1, '0, '0, t);
      beat(1'b0, 1'b1, 0, 4'd0, pat(201, 8'h66), {64{1'b1}}, t);
      idle();
      chk("err_midburst", 512'(err), 512'(1));
      get_beats(0, "ignored_read");
      clrq();
      rd(200, 4'd2, t);
      idle();
      get_beats(2, "midburst");
      chk("midburst_beat0", q_data[0], pat(200, 8'h66));
      chk("midburst_beat1", q_data[1], pat(201, 8'h66));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
